// File: rtl/jt7759_feeder.sv
// jt7759_feeder: streams a ROM byte block into the uPD7759 slave port over the DRQn/CS/WRn handshake.
// Define JT7759_FEEDER_WDOG_EN to add a WAIT watchdog that aborts the block and raises err.
module jt7759_feeder #(
    parameter int AW = 17,
    parameter int LW = 16,
    parameter int WR_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    input  logic          drqn,
    output logic          cs,
    output logic          wrn,
    output logic [7:0]    dout
);
    localparam int SW = $clog2(WR_LEN + 2);
    typedef enum logic [2:0] {IDLE, ARM, WAIT, STROBE, RELEASE} state_t;
    state_t st, st_n;
    logic [AW-1:0] ptr;
    logic [LW-1:0] fetch_left, write_left;
    logic [7:0] mem [2];
    logic wp, rp, holdoff, drqn_l, pend, stb_two, kill, trip, accept, pop, req, have;
    logic [1:0] cnt;
    logic [SW-1:0] stb_cnt;
    logic [SW:0] ticks;
    assign busy = st != IDLE;
    assign rom_addr = ptr;
    assign rom_cs = busy && !holdoff && cnt != 2'd2 && fetch_left != '0;
    assign accept = rom_cs && rom_ok;
    assign pop = st == RELEASE;
    assign cs = st == STROBE;
    assign wrn = st != STROBE;
    assign req = pend || (drqn_l && !drqn);
    assign have = cnt != 2'd0 || accept;
    assign ticks = {1'b0, stb_cnt} + {{SW{1'b0}}, cen};
    assign kill = abort || trip;
`ifdef JT7759_FEEDER_WDOG_EN
    logic [11:0] wd;
    assign trip = st == WAIT && wd == 12'hfff;
    always_ff @(posedge clk) begin
        if (rst || st != WAIT) wd <= '0;
        else if (cen) wd <= wd + 12'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (trip) err <= 1'b1;
        else if (st == IDLE && start && !abort) err <= 1'b0;
    end
`else
    assign trip = 1'b0;
    assign err = 1'b0;
`endif
    always_ff @(posedge clk) st <= rst ? IDLE : st_n;
    always_comb begin
        st_n = st;
        if (kill) st_n = IDLE;
        else case (st)
            IDLE:    if (start && len != '0) st_n = ARM;
            ARM:     if (drqn) st_n = WAIT;
            WAIT:    if (req && have) st_n = STROBE;
            STROBE:  if (stb_two && ticks >= (SW+1)'(WR_LEN)) st_n = RELEASE;
            RELEASE: st_n = write_left == LW'(1) ? IDLE : ARM;
            default: st_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            fetch_left <= '0;
            write_left <= '0;
            wp <= 1'b0;
            rp <= 1'b0;
            cnt <= 2'd0;
            holdoff <= 1'b0;
            drqn_l <= 1'b1;
            pend <= 1'b0;
            stb_cnt <= '0;
            stb_two <= 1'b0;
            dout <= 8'd0;
            done <= 1'b0;
        end else begin
            drqn_l <= drqn;
            done <= 1'b0;
            holdoff <= accept && !kill;
            stb_cnt <= st == STROBE ? ticks[SW-1:0] : '0;
            stb_two <= st == STROBE;
            if (kill) begin
                wp <= 1'b0;
                rp <= 1'b0;
                cnt <= 2'd0;
                pend <= 1'b0;
            end else begin
                if (st == IDLE && start) begin
                    ptr <= addr;
                    fetch_left <= len;
                    write_left <= len;
                    pend <= 1'b0;
                    done <= len == '0;
                end
                if (accept) begin
                    mem[wp] <= rom_data;
                    wp <= ~wp;
                    ptr <= ptr + 1'b1;
                    fetch_left <= fetch_left - 1'b1;
                end
                if (pop) begin
                    rp <= ~rp;
                    write_left <= write_left - 1'b1;
                    if (write_left == LW'(1)) done <= 1'b1;
                end
                cnt <= cnt + {1'b0, accept} - {1'b0, pop};
                // an empty buffer takes the byte straight from the ROM bus
                if (st == WAIT && req) begin
                    pend <= !have;
                    if (have) dout <= cnt != 2'd0 ? mem[rp] : rom_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_jt7759_feeder.sv
// tb_jt7759_feeder: scoreboard bench for jt7759_feeder; fetch addresses and written bytes are
// queued by the stimulus and matched by a negedge monitor.
module tb_jt7759_feeder;
    logic clk = 1'b0, rst = 1'b1, cen = 1'b1, start = 1'b0, abort = 1'b0, drqn = 1'b1;
    logic [16:0] addr = '0;
    logic [15:0] len = '0;
    logic busy, done, err, rom_cs, rom_ok, cs, wrn;
    logic [16:0] rom_addr;
    logic [7:0] rom_data, dout;
    int checks = 0, failures = 0, cyc = 0, lat = 0, wcnt = 0;
    int n_wr = 0, n_done = 0, n_romcs = 0, first_acc = -1, rise_cyc = -1, stb_len = 0, exp_len = 4;
    int p, w0, d0, r0;
    logic cs_q = 1'b0, hold_bad = 1'b0;
    logic [7:0] hold, eb;
    logic [16:0] ea;
    logic [16:0] addr_q[$];
    logic [7:0] byte_q[$];

    jt7759_feeder dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .abort(abort), .addr(addr), .len(len),
        .busy(busy), .done(done), .err(err), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok), .drqn(drqn), .cs(cs), .wrn(wrn), .dout(dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        wcnt <= rom_cs ? wcnt + 1 : 0;
    end
    assign rom_ok = rom_cs && wcnt >= lat;
    assign rom_data = rom_addr[7:0] ^ rom_addr[15:8] ^ {7'd0, rom_addr[16]} ^ 8'ha5;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        if (rom_cs) n_romcs++;
        if (rom_cs && rom_ok) begin
            if (first_acc < 0) first_acc = cyc;
            if (addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rom_addr_extra: got %0h expected no fetch", rom_addr);
            end else begin
                ea = addr_q.pop_front();
                chk("rom_addr", rom_addr, ea);
            end
        end
        if (cs && !cs_q) begin
            n_wr++;
            rise_cyc = cyc;
            stb_len = 1;
            hold = dout;
            hold_bad = 1'b0;
            chk("wrn_low", wrn, 0);
            if (byte_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dout_extra: got %0h expected no write", dout);
            end else begin
                eb = byte_q.pop_front();
                chk("dout", dout, eb);
            end
        end else if (cs) begin
            stb_len++;
            if (dout != hold) hold_bad = 1'b1;
        end
        if (!cs && cs_q) begin
            chk("strobe_len", stb_len, exp_len);
            chk("dout_hold", hold_bad, 0);
            chk("wrn_high", wrn, 1);
        end
        if (done) n_done++;
        cs_q = cs;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [16:0] a, input logic [15:0] l);
        addr = a;
        len = l;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic drq(input int lo, input int hi);
        drqn = 1'b0;
        tick(lo);
        drqn = 1'b1;
        tick(hi);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        chk("rst_cs", cs, 0);
        chk("rst_wrn", wrn, 1);
        chk("rst_dout", dout, 0);
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick(2);

        addr_q.push_back(17'h00100); addr_q.push_back(17'h00101); addr_q.push_back(17'h00102);
        byte_q.push_back(8'ha4); byte_q.push_back(8'ha5); byte_q.push_back(8'ha6);
        go(17'h00100, 16'd3);
        chk("t1_busy_on", busy, 1);
        tick(6);
        drqn = 1'b0;
        p = cyc;
        tick(2);
        drqn = 1'b1;
        tick(8);
        chk("t1_latency", rise_cyc - p, 1);
        drq(2, 8);
        drq(2, 8);
        chk("t1_writes", n_wr, 3);
        chk("t1_done", n_done, 1);
        chk("t1_busy_off", busy, 0);

        addr_q.push_back(17'h00140); addr_q.push_back(17'h00141);
        byte_q.push_back(8'he4); byte_q.push_back(8'he5);
        w0 = n_wr; d0 = n_done;
        go(17'h00140, 16'd2);
        tick(6);
        drqn = 1'b0;
        tick(50);
        chk("t2_held_one", n_wr - w0, 1);
        drqn = 1'b1;
        tick(5);
        drq(2, 10);
        chk("t2_second", n_wr - w0, 2);
        chk("t2_done", n_done - d0, 1);

        lat = 10;
        addr_q.push_back(17'h00180);
        byte_q.push_back(8'h24);
        w0 = n_wr; d0 = n_done; first_acc = -1;
        go(17'h00180, 16'd1);
        tick(1);
        drqn = 1'b0;
        tick(30);
        chk("t3_pending", n_wr - w0, 1);
        chk("t3_after_ok", rise_cyc - first_acc, 1);
        drqn = 1'b1;
        tick(5);
        chk("t3_done", n_done - d0, 1);
        lat = 0;

        w0 = n_wr; d0 = n_done; r0 = n_romcs;
        go(17'h00055, 16'd0);
        @(negedge clk);
        chk("t4_done_pulse", done, 1);
        chk("t4_busy", busy, 0);
        @(negedge clk);
        chk("t4_done_clear", done, 0);
        tick(3);
        chk("t4_romcs", n_romcs - r0, 0);
        chk("t4_cs", n_wr - w0, 0);
        chk("t4_done_count", n_done - d0, 1);

        addr_q.push_back(17'h1ffff); addr_q.push_back(17'h00000);
        byte_q.push_back(8'ha4); byte_q.push_back(8'ha5);
        d0 = n_done;
        go(17'h1ffff, 16'd2);
        tick(6);
        drq(2, 8);
        drq(2, 8);
        chk("t5_done", n_done - d0, 1);
        chk("t5_ptr_wrap", rom_addr, 1);

        r0 = n_romcs;
        addr = 17'h00200; len = 16'd1; start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        tick(2);
        chk("t6_no_start", busy, 0);
        chk("t6_no_fetch", n_romcs - r0, 0);

        addr_q.push_back(17'h00200);
        byte_q.push_back(8'ha7);
        exp_len = 2; d0 = n_done; w0 = n_wr;
        go(17'h00200, 16'd1);
        tick(4);
        drqn = 1'b0;
        tick(2);
        chk("t6_in_strobe", cs, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t6_abort_cs", cs, 0);
        chk("t6_abort_wrn", wrn, 1);
        chk("t6_abort_busy", busy, 0);
        drqn = 1'b1;
        tick(5);
        chk("t6_no_done", n_done - d0, 0);
        exp_len = 4;
        addr_q.push_back(17'h00300);
        byte_q.push_back(8'ha6);
        go(17'h00300, 16'd1);
        tick(6);
        drq(2, 8);
        chk("t6_restart_done", n_done - d0, 1);
        chk("t6_writes", n_wr - w0, 2);

`ifdef JT7759_FEEDER_WDOG_EN
        addr_q.push_back(17'h00400);
        go(17'h00400, 16'd1);
        begin
            int i;
            for (i = 0; i < 5000 && busy; i++) tick(1);
            chk("wd_time", int'(i >= 4090 && i <= 4100), 1);
        end
        chk("wd_busy", busy, 0);
        chk("wd_err", err, 1);
        go(17'h00000, 16'd0);
        tick(1);
        chk("wd_err_clear", err, 0);
`endif

        chk("addr_q_empty", addr_q.size(), 0);
        chk("byte_q_empty", byte_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
